// File: rtl/ctrl_flow_sequencer_if.sv
// Decoder-to-sequencer instruction handshake: one decoded control instruction per vld/rdy transfer.
interface ctrl_flow_sequencer_if #(
   parameter int STACK_W = 28,
   parameter int ADDR_W  = 18,
   parameter int DEPTH_W = 8
);
   logic               instr_vld;
   logic               instr_rdy;
   logic [2:0]         instr_op;
   logic [DEPTH_W-1:0] instr_depth;
   logic [STACK_W-1:0] instr_frame;
   logic [ADDR_W-1:0]  instr_target;

   modport master (
      output instr_vld, instr_op, instr_depth, instr_frame, instr_target,
      input  instr_rdy
   );

   modport slave (
      input  instr_vld, instr_op, instr_depth, instr_frame, instr_target,
      output instr_rdy
   );
endinterface

// File: rtl/ctrl_flow_sequencer.sv
// WASM structured-control-flow sequencer driving the control stack; optional
// overflow/underflow guarding is enabled with CTRL_SEQ_GUARD_EN.
//
// state    | meaning
// S_IDLE   | ready, waiting for an instruction
// S_EXEC   | single-cycle push/call/end/return/br0/illegal
// S_BR_POP | popping the N intermediate frames of br N
// S_BR_TGT | resolving the br target frame (loop keeps it, others pop it)
module ctrl_flow_sequencer #(
   parameter int STACK_W   = 28,
   parameter int ADDR_W    = 18,
   parameter int DEPTH_W   = 8,
   parameter int LOG_DEPTH = 5,
   parameter int FUNC_MAX  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ctrl_flow_sequencer_if.slave    instr_if,
   output logic                    cs_shift_vld,
   output logic                    cs_push,
   output logic                    cs_pop,
   output logic                    cs_retu,
   output logic                    cs_function_call,
   output logic [STACK_W-1:0]      cs_push_data,
   input  logic [STACK_W-1:0]      cs_top_data,
   output logic                    jump_vld,
   output logic [ADDR_W-1:0]       jump_addr,
   output logic                    busy,
   output logic                    err,
   output logic [LOG_DEPTH:0]      occupancy
);
   localparam int OCC_W = LOG_DEPTH + 1;
   localparam int IDX_W = $clog2(FUNC_MAX);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(1 << LOG_DEPTH);
   localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(FUNC_MAX);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_CALL = 3'd1;
   localparam logic [2:0] OP_END  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BR_POP, S_BR_TGT} state_t;

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [STACK_W-1:0]   frame_q, frame_d;
   logic [ADDR_W-1:0]    target_q, target_d;
   logic [DEPTH_W-1:0]   cnt_q, cnt_d;
   logic                 bad_q, bad_d;
   logic [OCC_W-1:0]     occ_q, occ_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [OCC_W-1:0]     call_base_q [FUNC_MAX];
   logic [OCC_W-1:0]     call_base_d [FUNC_MAX];
   logic                 err_q, err_d;
   logic                 jump_vld_q, jump_vld_d;
   logic [ADDR_W-1:0]    jump_addr_q, jump_addr_d;

   logic                 viol_in;
   logic                 br_tgt;
   logic [1:0]           top_type;
   logic [ADDR_W-1:0]    top_addr;
   logic [PTR_W-1:0]     ptr_m1;
   logic                 unused_top;

   assign top_type   = cs_top_data[STACK_W-1 -: 2];
   assign top_addr   = cs_top_data[ADDR_W-1:0];
   assign unused_top = ^cs_top_data[STACK_W-3:ADDR_W];
   assign ptr_m1     = ptr_q - PTR_ONE;

   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;
   assign jump_vld  = jump_vld_q;
   assign jump_addr = jump_addr_q;
   assign occupancy = occ_q;

   // Guard decision is taken on the incoming instruction so a rejected br never enters S_BR_POP.
   always_comb begin
      viol_in = 1'b0;
`ifdef CTRL_SEQ_GUARD_EN
      case (instr_if.instr_op)
         OP_PUSH: viol_in = (occ_q == OCC_FULL);
         OP_CALL: viol_in = (occ_q == OCC_FULL) || (ptr_q == PTR_FULL);
         OP_END:  viol_in = (occ_q == '0);
         OP_BR:   viol_in = (32'(occ_q) <= 32'(instr_if.instr_depth));
         OP_RET:  viol_in = (occ_q == '0) || (ptr_q == '0);
         default: viol_in = 1'b0;
      endcase
`endif
   end

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      frame_d          = frame_q;
      target_d         = target_q;
      cnt_d            = cnt_q;
      bad_d            = bad_q;
      occ_d            = occ_q;
      ptr_d            = ptr_q;
      call_base_d      = call_base_q;
      err_d            = err_q;
      jump_vld_d       = 1'b0;
      jump_addr_d      = jump_addr_q;
      cs_shift_vld     = 1'b0;
      cs_push          = 1'b0;
      cs_pop           = 1'b0;
      cs_retu          = 1'b0;
      cs_function_call = 1'b0;
      cs_push_data     = '0;
      instr_if.instr_rdy = 1'b0;
      br_tgt           = 1'b0;

      case (state_q)
         S_IDLE: begin
            instr_if.instr_rdy = 1'b1;
            if (instr_if.instr_vld) begin
               op_d     = instr_if.instr_op;
               frame_d  = instr_if.instr_frame;
               target_d = instr_if.instr_target;
               cnt_d    = instr_if.instr_depth;
               bad_d    = viol_in;
               if (instr_if.instr_op == OP_BR && instr_if.instr_depth != '0 && !viol_in)
                  state_d = S_BR_POP;
               else
                  state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            if (bad_q) begin
               err_d = 1'b1;
            end else begin
               case (op_q)
                  OP_PUSH: begin
                     cs_shift_vld = 1'b1;
                     cs_push      = 1'b1;
                     cs_push_data = frame_q;
                     occ_d        = occ_q + OCC_ONE;
                  end
                  OP_CALL: begin
                     cs_shift_vld     = 1'b1;
                     cs_push          = 1'b1;
                     cs_function_call = 1'b1;
                     cs_push_data     = frame_q;
                     call_base_d[ptr_q[IDX_W-1:0]] = occ_q;
                     ptr_d            = ptr_q + PTR_ONE;
                     occ_d            = occ_q + OCC_ONE;
                  end
                  OP_END: begin
                     cs_shift_vld = 1'b1;
                     cs_pop       = 1'b1;
                     occ_d        = occ_q - OCC_ONE;
                     if (top_type == 2'b01) begin
                        ptr_d       = ptr_m1;
                        jump_vld_d  = 1'b1;
                        jump_addr_d = top_addr;
                     end
                  end
                  OP_RET: begin
                     cs_shift_vld = 1'b1;
                     cs_retu      = 1'b1;
                     cs_pop       = 1'b1;
                     occ_d        = call_base_q[ptr_m1[IDX_W-1:0]];
                     ptr_d        = ptr_m1;
                     jump_vld_d   = 1'b1;
                     jump_addr_d  = top_addr;
                  end
                  OP_BR:   br_tgt = 1'b1;
                  default: err_d  = 1'b1;
               endcase
            end
         end
         S_BR_POP: begin
            cs_shift_vld = 1'b1;
            cs_pop       = 1'b1;
            occ_d        = occ_q - OCC_ONE;
            cnt_d        = cnt_q - DEPTH_W'(1);
            if (cnt_q == DEPTH_W'(1))
               state_d = S_BR_TGT;
         end
         S_BR_TGT: begin
            br_tgt  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A loop target re-enters the loop and keeps its frame; block/if exit past their end.
      if (br_tgt) begin
         jump_vld_d = 1'b1;
         if (top_type == 2'b11) begin
            jump_addr_d = top_addr;
         end else begin
            cs_shift_vld = 1'b1;
            cs_pop       = 1'b1;
            occ_d        = occ_q - OCC_ONE;
            jump_addr_d  = target_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         frame_q     <= '0;
         target_q    <= '0;
         cnt_q       <= '0;
         bad_q       <= 1'b0;
         occ_q       <= '0;
         ptr_q       <= '0;
         call_base_q <= '{default: '0};
         err_q       <= 1'b0;
         jump_vld_q  <= 1'b0;
         jump_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         frame_q     <= frame_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         bad_q       <= bad_d;
         occ_q       <= occ_d;
         ptr_q       <= ptr_d;
         call_base_q <= call_base_d;
         err_q       <= err_d;
         jump_vld_q  <= jump_vld_d;
         jump_addr_q <= jump_addr_d;
      end
   end
endmodule

// File: doc/ctrl_flow_sequencer.md
Name: ctrl_flow_sequencer

Overview:
- Sequences the WASM control stack for structured control flow: block/loop/if/call frame pushes, end, br N and return.
- Accepts one decoded control instruction at a time from the decoder and drives the control stack's shift_vld/push/pop/retu/function_call, one stack operation per cycle.
- Emits a jump request (target PC) to the fetch unit.
- Keeps a shadow occupancy count and a call-base list, so it detects overflow/underflow and knows stack depth after return.

Parameters:
- STACK_W, 28: control-stack frame width. Frame type is [STACK_W-1:STACK_W-2]: 01 call, 11 loop, 00 block, 10 if. Return address is [ADDR_W-1:0].
- ADDR_W, 18: instruction address width.
- DEPTH_W, 8: width of the br label depth.
- LOG_DEPTH, 5: log2 of control-stack depth. Depth is 2^LOG_DEPTH = 32.
- FUNC_MAX, 16: maximum nested calls tracked.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr_vld  in  1  instruction valid
- instr_rdy  out  1  sequencer ready to accept an instruction
- instr_op  in  3  000 PUSH, 001 CALL, 010 END, 011 BR, 100 RETURN; others illegal
- instr_depth  in  DEPTH_W  br label depth N
- instr_frame  in  STACK_W  frame to push for PUSH/CALL
- instr_target  in  ADDR_W  end address used when the br target is block/if
- cs_shift_vld  out  1  stack op strobe
- cs_push  out  1  push strobe
- cs_pop  out  1  pop strobe
- cs_retu  out  1  return strobe
- cs_function_call  out  1  function-call strobe
- cs_push_data  out  STACK_W  frame written on push
- cs_top_data  in  STACK_W  current top frame from the stack
- jump_vld  out  1  one-cycle jump request
- jump_addr  out  ADDR_W  jump target
- busy  out  1  instruction in flight
- err  out  1  sticky error flag
- occupancy  out  LOG_DEPTH+1  shadow stack depth

Behaviour:
- Reset: synchronous, on a rising clk edge with rst_n=0.
  - State=IDLE; occupancy=0; call-base pointer=0; err=0.
  - jump_vld=0, jump_addr=0; all cs_* outputs=0; instr_rdy=1.
  - Reset mid-instruction abandons it; no further stack ops are issued.
- instr_rdy=1 only in IDLE. Accept = instr_vld & instr_rdy. On accept, op/depth/frame/target are latched and the FSM moves to EXEC (BR with N>0 goes to BR_POP instead).
- busy = (state != IDLE).
- cs_* outputs are combinational from state and latched registers. cs_shift_vld=1 exactly in cycles that issue a stack op.
- EXEC:
  - PUSH: push=1 with the latched frame; occupancy+1.
  - CALL: push=1 and function_call=1. The current occupancy is saved at call-base[ptr]; ptr+1; occupancy+1.
  - END: pop=1; occupancy-1. If the cs_top_data type is 01: ptr-1, plus a jump to top[ADDR_W-1:0].
  - RETURN: retu=1 and pop=1; occupancy set to call-base[ptr-1]; ptr-1; jump to top[ADDR_W-1:0].
  - BR with N=0 behaves as BR_TGT.
  - Next state is IDLE.
- BR_POP:
  - Internal counter loaded with N on accept.
  - Each cycle: pop=1, occupancy-1, counter-1.
  - When the counter reaches 1 on a pop, next state is BR_TGT.
- BR_TGT:
  - Target frame type 11 (loop): no pop, shift_vld=0; jump to top[ADDR_W-1:0].
  - Other types: pop=1, occupancy-1; jump to the latched instr_target.
  - Next state is IDLE.
- Total BR latency is N+1 cycles after accept.
- jump_vld is registered: high for exactly the one cycle after the final stack-op cycle, with jump_addr valid. jump_addr holds its value otherwise.
- Illegal op: consumed in one EXEC cycle with no stack op; err set.

Optional Feature:
- CTRL_SEQ_GUARD_EN defined:
  - A push with occupancy=32 or a CALL with ptr=FUNC_MAX is suppressed (no cs_push) and sets err.
  - A pop/BR/RETURN with occupancy=0, or with fewer than N+1 frames for BR, or RETURN with ptr=0: no stack ops are issued, err is set, no jump is made, and the FSM returns to IDLE.
- Not defined: no checks; ops are issued unconditionally and err is driven only by illegal op.

Test Plan:
- Reset, then PUSH frame 0x0000000 (block) → cs_push=1 one cycle after accept, occupancy=1, no jump_vld, instr_rdy back to 1 after 1 cycle.
- CALL frame {01,…,ret=0x00123}, then RETURN → retu=1 and pop=1 in a single cycle; next cycle jump_vld=1 with jump_addr=0x00123; occupancy restored to its pre-CALL value.
- Push block, loop(ret=0x00040), block, block, then BR N=2 → 2 pop cycles, then BR_TGT with no pop; jump_addr=0x00040, occupancy=2, busy for 3 cycles.
- Push block, block, then BR N=1 with instr_target=0x00200 → 2 pops; jump_addr=0x00200, occupancy=0.
- With CTRL_SEQ_GUARD_EN: END at occupancy=0 → no cs_shift_vld, err=1 (sticky), no jump; 33rd PUSH suppressed with err=1.
- Assert rst_n=0 during BR_POP with N=5 at cycle 2 → next cycle IDLE, all cs_* outputs 0, occupancy=0, err=0.
